// File: rtl/string_assembler.sv
// Packs a valid/ready byte stream into a null-padded 64-bit string, first byte in [7:0],
// and holds each finished string with its byte count until downstream takes it.
module string_assembler #(
  parameter int unsigned IDLE_LIMIT = 16
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [7:0]  in_byte_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [63:0] string_o,
  output logic [3:0]  count_o,
  output logic        string_valid_o,
  input  logic        string_ready_i
);

  localparam int unsigned IW = (IDLE_LIMIT < 2) ? 1 : $clog2(IDLE_LIMIT + 1);
  localparam logic [IW-1:0] LIMIT_M1 = IW'((IDLE_LIMIT > 0) ? IDLE_LIMIT - 1 : 0);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state_q;
  logic [63:0]   string_q;
  logic [3:0]    count_q;
  logic [IW-1:0] idle_q;
  logic          accept_d;
  logic [5:0]    lane_lsb_d;

  assign accept_d   = in_valid_i && (state_q == FILL);
  assign lane_lsb_d = {count_q[2:0], 3'b000};

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= FILL;
      string_q <= '0;
      count_q  <= '0;
      idle_q   <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept_d) begin
            idle_q <= '0;
            if (in_byte_i == 8'h00) begin
              state_q <= HOLD;
            end else begin
              string_q[lane_lsb_d +: 8] <= in_byte_i;
              count_q                   <= count_q + 4'd1;
              if (count_q == 4'd7) begin
                state_q <= HOLD;
              end
            end
          end else if ((IDLE_LIMIT != 0) && (count_q != 4'd0)) begin
            // An empty buffer never times out, so idling before the first byte is harmless.
            idle_q <= idle_q + 1'b1;
            if (idle_q == LIMIT_M1) begin
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (string_ready_i) begin
            state_q  <= FILL;
            string_q <= '0;
            count_q  <= '0;
            idle_q   <= '0;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign in_ready_o     = (state_q == FILL);
  assign string_valid_o = (state_q == HOLD);
  assign string_o       = string_q;
  assign count_o        = count_q;

endmodule
